muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl.sv | 99 +++++++++
 tb/tb_muldiv_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MULT/DIV through the external units and owns HI/LO
//   clock, reset                          rising-edge clock, async active-high reset
//   op_valid, op_div, rs_val, rt_val      request strobe, DIV select, operands
//   hi_we, lo_we, wdata                   MTHI/MTLO writes (honoured only while idle)
//   unit_a, unit_b                        latched operands to both units
//   mult_start, div_start                 one-cycle start pulses
//   mult_hi, mult_lo, div_quot, div_rem   unit results
//   hi, lo                                architectural HI/LO
//   busy, done, div_zero                  status; done/div_zero are one-cycle pulses
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_div,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mult_start,
    output logic        div_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_N + 1);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic is_div, idle, dz, accept, fin;
    logic mult_start_nxt, div_start_nxt, done_nxt, div_zero_nxt;
    assign idle   = state == S_IDLE;
    // divide by zero never reaches the divider; it completes on the spot
    assign dz     = idle && op_valid && op_div && rt_val == '0;
    assign accept = idle && op_valid && !dz;
    assign fin    = state == S_WAIT && cnt == '0;
    assign busy   = !idle;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? S_LAUNCH :
                    state == S_LAUNCH ? S_WAIT :
                    fin ? S_IDLE : state;
    end
    always_comb begin
        mult_start_nxt = accept && !op_div;
        div_start_nxt  = accept && op_div;
        done_nxt       = fin || dz;
        div_zero_nxt   = dz;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            is_div     <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
            hi         <= '0;
            lo         <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            mult_start <= mult_start_nxt;
            div_start  <= div_start_nxt;
            done       <= done_nxt;
            div_zero   <= div_zero_nxt;
            if (accept) begin
                unit_a <= rs_val;
                unit_b <= rt_val;
                is_div <= op_div;
            end
            if (state == S_LAUNCH) cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (state == S_WAIT && cnt != '0) cnt <= cnt - CW'(1);
            // the divider returns remainder in HI and quotient in LO
            if (fin) begin
                hi <= is_div ? div_rem : mult_hi;
                lo <= is_div ? div_quot : mult_lo;
            end else if (idle) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench with a cycle-time model of muldiv_ctrl
module tb_muldiv_ctrl;
    localparam int N = 32;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic op_valid = 1'b0, op_div = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic [31:0] unit_a, unit_b, mult_hi, mult_lo, div_quot, div_rem, hi, lo;
    logic mult_start, div_start, busy, done, div_zero;
    logic [63:0] uprod;
    int total = 0, bad = 0;
    int now, t_end;
    bit in_flight;
    bit e_busy, e_ms, e_ds, e_done, e_dz, n_ms, n_ds, n_done, n_dz;
    logic [31:0] e_hi, e_lo, e_a, e_b, res_hi, res_lo;
    int ms_n, ds_n, ms_at, done_at;

    muldiv_ctrl dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_div(op_div),
        .rs_val(rs_val), .rt_val(rt_val), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .unit_a(unit_a), .unit_b(unit_b), .mult_start(mult_start), .div_start(div_start),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_quot(div_quot), .div_rem(div_rem),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    // stand-in units: results follow the latched operands
    assign uprod    = longint'($signed(unit_a)) * longint'($signed(unit_b));
    assign mult_hi  = uprod[63:32];
    assign mult_lo  = uprod[31:0];
    assign div_quot = (unit_b == 32'h0) ? 32'h0 : 32'($signed(unit_a) / $signed(unit_b));
    assign div_rem  = (unit_b == 32'h0) ? 32'h0 : 32'($signed(unit_a) % $signed(unit_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_result(input logic d, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (d) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // model: `now` counts rising edges since reset; an op accepted at edge t0
    // shows its start pulse after t0 and completes at edge t0+N+2
    always @(negedge clock) begin
        if (reset) begin
            now = 0; in_flight = 0;
            {e_busy, e_ms, e_ds, e_done, e_dz} = '0;
            e_hi = '0; e_lo = '0; e_a = '0; e_b = '0;
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("mult_start", 32'(mult_start), 32'(e_ms));
        chk("div_start", 32'(div_start), 32'(e_ds));
        chk("done", 32'(done), 32'(e_done));
        chk("div_zero", 32'(div_zero), 32'(e_dz));
        chk("hi", hi, e_hi);
        chk("lo", lo, e_lo);
        chk("unit_a", unit_a, e_a);
        chk("unit_b", unit_b, e_b);
        if (!reset) begin
            {n_ms, n_ds, n_done, n_dz} = '0;
            if (!e_busy) begin
                if (hi_we) e_hi = wdata;
                if (lo_we) e_lo = wdata;
                if (op_valid && op_div && rt_val == 32'h0) begin
                    n_done = 1; n_dz = 1;
                end else if (op_valid) begin
                    in_flight = 1;
                    t_end = now + 1 + N + 2;
                    e_a = rs_val; e_b = rt_val;
                    {res_hi, res_lo} = model_result(op_div, rs_val, rt_val);
                    n_ms = !op_div; n_ds = op_div;
                end
            end
            now++;
            if (in_flight && now == t_end) begin
                e_hi = res_hi; e_lo = res_lo; n_done = 1; in_flight = 0;
            end
            e_busy = in_flight; e_ms = n_ms; e_ds = n_ds; e_done = n_done; e_dz = n_dz;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // issue one request; positions are counted in edges after the accept edge
    task automatic do_op(input logic d, input logic [31:0] a, input logic [31:0] b, input int mtlo_at);
        op_valid = 1; op_div = d; rs_val = a; rt_val = b;
        step();
        op_valid = 0;
        ms_n = int'(mult_start); ds_n = int'(div_start);
        ms_at = mult_start ? 0 : -1; done_at = -1;
        for (int i = 1; i <= 60 && done_at < 0; i++) begin
            lo_we = (i == mtlo_at); wdata = 32'h1;
            step();
            if (mult_start) begin ms_n++; ms_at = i; end
            ds_n += int'(div_start);
            if (done) done_at = i;
        end
        lo_we = 0;
    endtask

    initial begin
        int d1, d2, cnt;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset hi", hi, 32'h0);
        chk("reset unit_a", unit_a, 32'h0);
        reset = 0;
        step(); step();
        // MULT 7 x -3
        do_op(0, 32'd7, 32'hFFFF_FFFD, -1);
        chk("mul start count", ms_n, 1);
        chk("mul start pos", ms_at, 0);
        chk("mul no div_start", ds_n, 0);
        chk("mul latency", done_at, 34);
        chk("mul hi", hi, 32'hFFFF_FFFF);
        chk("mul lo", lo, 32'hFFFF_FFEB);
        step();
        // DIV 100 / 7
        do_op(1, 32'd100, 32'd7, -1);
        chk("div start count", ds_n, 1);
        chk("div no mult_start", ms_n, 0);
        chk("div latency", done_at, 34);
        chk("div lo", lo, 32'd14);
        chk("div hi", hi, 32'd2);
        step();
        // preload then DIV 5 / 0
        hi_we = 1; wdata = 32'hAAAA_0000; step();
        hi_we = 0; lo_we = 1; wdata = 32'h5555; step();
        lo_we = 0;
        op_valid = 1; op_div = 1; rs_val = 32'd5; rt_val = 32'd0;
        step();
        op_valid = 0;
        chk("dz done", 32'(done), 32'h1);
        chk("dz div_zero", 32'(div_zero), 32'h1);
        chk("dz busy", 32'(busy), 32'h0);
        chk("dz no start", 32'(mult_start | div_start), 32'h0);
        step();
        chk("dz done fall", 32'(done), 32'h0);
        chk("dz hi kept", hi, 32'hAAAA_0000);
        chk("dz lo kept", lo, 32'h5555);
        // back-to-back MULTs with op_valid held
        op_valid = 1; op_div = 0; rs_val = 32'd3; rt_val = 32'd5;
        step();
        chk("b2b first start", 32'(mult_start), 32'h1);
        rs_val = 32'd6; rt_val = 32'd7;
        ms_n = 0; ms_at = -1; d1 = -1; d2 = -1;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (i == 10) chk("b2b unit_a held", unit_a, 32'd3);
            if (mult_start) begin ms_n++; ms_at = i; end
            if (done) begin
                if (d1 < 0) d1 = i;
                else d2 = i;
            end
            if (i == 35) op_valid = 0;
        end
        chk("b2b first done", d1, 34);
        chk("b2b second start count", ms_n, 1);
        chk("b2b second start pos", ms_at, 35);
        chk("b2b second done", d2, 69);
        chk("b2b lo", lo, 32'd42);
        chk("b2b hi", hi, 32'd0);
        // reset on the 10th WAIT cycle of a DIV
        op_valid = 1; op_div = 1; rs_val = 32'd50; rt_val = 32'd3;
        step();
        op_valid = 0;
        repeat (10) step();
        chk("rst pre busy", 32'(busy), 32'h1);
        reset = 1;
        #1;
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst div_start", 32'(div_start), 32'h0);
        chk("rst hi", hi, 32'h0);
        chk("rst lo", lo, 32'h0);
        chk("rst unit_a", unit_a, 32'h0);
        step();
        reset = 0;
        cnt = 0;
        repeat (40) begin
            step();
            cnt += int'(done);
        end
        chk("rst no done", cnt, 0);
        // MTHI while idle, MTLO dropped while busy
        hi_we = 1; wdata = 32'h1234_5678;
        step();
        hi_we = 0;
        chk("mthi", hi, 32'h1234_5678);
        do_op(0, 32'd9, 32'd10, 5);
        chk("mtlo busy latency", done_at, 34);
        chk("mtlo busy lo", lo, 32'd90);
        chk("mtlo busy hi", hi, 32'd0);
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
